// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong game-rule logic: FSM state encoding, winner
// codes, life/counter widths and a saturating decrement helper.
// No ports (package).
// -----------------------------------------------------------------------------
package pong_pkg;

  localparam int LIVES_W = 2;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SERVE    = 2'd1,
    ST_PLAY     = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Decrement that sticks at zero, so a miss on an already-empty count
  // (only reachable from a corrupted state) cannot wrap to full lives.
  function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] v);
    return (v == '0) ? '0 : v - LIVES_W'(1);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// -----------------------------------------------------------------------------
// frame_counter
// 8-bit frame_tick counter with synchronous clear and a terminal-count compare.
// Shared by the serve delay and the optional game-over timeout.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over tick)
//   tick       : count enable, one pulse per video frame
//   tc         : terminal count (number of ticks to wait minus one)
//   hit        : tick arriving while the count equals tc
// -----------------------------------------------------------------------------
module frame_counter
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] tc,
  output logic             hit
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (tick) count_d = count_q + CNT_W'(1);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // hit deliberately ignores clr: the owner's next-state logic consumes hit
  // and also produces clr, so gating here would close a combinational loop.
  assign hit = tick && (count_q == tc);

endmodule

// File: rtl/lives_tracker.sv
// -----------------------------------------------------------------------------
// lives_tracker
// Game-rule stage feeding the heart display. Turns ball-miss levels into
// per-player life counts and sequences serve delay / game over.
// Optional feature macro: LIVES_AUTO_RESTART_EN -- when defined, GAME_OVER
// returns to IDLE by itself after GO_FRAMES frame ticks.
// Ports:
//   clk, rst_n    : pixel clock, asynchronous active-low reset
//   frame_tick    : one-cycle pulse per video frame
//   start         : debounced start button (level, rising edge used)
//   miss1, miss2  : high while the ball is past player-1 / player-2 edge
//   lives1,lives2 : remaining lives (0..3) to the heart renderer
//   ball_reset    : hold the ball at centre
//   play_active   : high only in PLAY
//   game_over     : high only in GAME_OVER
//   winner        : 00 none, 01 P1, 10 P2, 11 draw (valid with game_over)
// -----------------------------------------------------------------------------
module lives_tracker
  import pong_pkg::*;
#(
  parameter int INIT_LIVES   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int GO_FRAMES    = 180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss1,
  input  logic               miss2,
  output logic [LIVES_W-1:0] lives1,
  output logic [LIVES_W-1:0] lives2,
  output logic               ball_reset,
  output logic               play_active,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [LIVES_W-1:0] INIT_L   = LIVES_W'(INIT_LIVES);
  localparam logic [CNT_W-1:0]   SERVE_TC = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   GO_TC    = CNT_W'(GO_FRAMES - 1);

  state_t              state_q, state_d;
  logic [LIVES_W-1:0]  lives1_q, lives1_d;
  logic [LIVES_W-1:0]  lives2_q, lives2_d;
  winner_t             winner_q, winner_d;
  logic                ball_reset_q, ball_reset_d;
  logic                play_active_q, play_active_d;
  logic                game_over_q, game_over_d;
  logic                start_prev_q, miss1_prev_q, miss2_prev_q;

  logic                start_rise, miss1_ev, miss2_ev;
  logic [LIVES_W-1:0]  nl1, nl2;
  logic                cnt_run, cnt_clr, cnt_hit;
  logic [CNT_W-1:0]    cnt_tc;

  assign start_rise = start & ~start_prev_q;
  assign miss1_ev   = miss1 & ~miss1_prev_q;
  assign miss2_ev   = miss2 & ~miss2_prev_q;

  // Lives after this cycle's miss events; only applied in PLAY.
  assign nl1 = miss1_ev ? sat_dec(lives1_q) : lives1_q;
  assign nl2 = miss2_ev ? sat_dec(lives2_q) : lives2_q;

  // Counter runs only in tick-counting states and restarts from zero on every
  // state change, so a tick coincident with a transition is never carried in.
`ifdef LIVES_AUTO_RESTART_EN
  assign cnt_run = (state_q == ST_SERVE) || (state_q == ST_GAMEOVER);
`else
  assign cnt_run = (state_q == ST_SERVE);
`endif
  assign cnt_clr = !cnt_run || (state_d != state_q);
  assign cnt_tc  = (state_q == ST_GAMEOVER) ? GO_TC : SERVE_TC;

  frame_counter u_frame_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .tick  (frame_tick),
    .tc    (cnt_tc),
    .hit   (cnt_hit)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d  = state_q;
    lives1_d = lives1_q;
    lives2_d = lives2_q;
    winner_d = winner_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          lives1_d = INIT_L;
          lives2_d = INIT_L;
          winner_d = WIN_NONE;
          state_d  = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (cnt_hit) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (miss1_ev || miss2_ev) begin
          lives1_d = nl1;
          lives2_d = nl2;
          if (nl1 == '0 || nl2 == '0) begin
            state_d = ST_GAMEOVER;
            if (nl1 == '0 && nl2 == '0) winner_d = WIN_DRAW;
            else if (nl1 == '0)         winner_d = WIN_P2;
            else                        winner_d = WIN_P1;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end

      ST_GAMEOVER: begin
        if (start_rise) begin
          lives1_d = INIT_L;
          lives2_d = INIT_L;
          winner_d = WIN_NONE;
          state_d  = ST_SERVE;
        end
`ifdef LIVES_AUTO_RESTART_EN
        else if (cnt_hit) begin
          lives1_d = INIT_L;
          lives2_d = INIT_L;
          winner_d = WIN_NONE;
          state_d  = ST_IDLE;
        end
`endif
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    ball_reset_d  = (state_d != ST_PLAY);
    play_active_d = (state_d == ST_PLAY);
    game_over_d   = (state_d == ST_GAMEOVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lives1_q      <= INIT_L;
      lives2_q      <= INIT_L;
      winner_q      <= WIN_NONE;
      ball_reset_q  <= 1'b1;
      play_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      start_prev_q  <= 1'b0;
      miss1_prev_q  <= 1'b0;
      miss2_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives1_q      <= lives1_d;
      lives2_q      <= lives2_d;
      winner_q      <= winner_d;
      ball_reset_q  <= ball_reset_d;
      play_active_q <= play_active_d;
      game_over_q   <= game_over_d;
      start_prev_q  <= start;
      miss1_prev_q  <= miss1;
      miss2_prev_q  <= miss2;
    end
  end

  assign lives1      = lives1_q;
  assign lives2      = lives2_q;
  assign ball_reset  = ball_reset_q;
  assign play_active = play_active_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_lives_tracker.sv
// -----------------------------------------------------------------------------
// tb_lives_tracker
// Directed self-checking bench for lives_tracker with default parameters
// (INIT_LIVES=3, SERVE_FRAMES=60, GO_FRAMES=180). Inputs change and outputs
// are sampled on the falling edge of clk. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_lives_tracker;

  localparam int SERVE_N = 60;
  localparam int GO_N    = 180;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       miss1 = 1'b0;
  logic       miss2 = 1'b0;
  logic [1:0] lives1, lives2, winner;
  logic       ball_reset, play_active, game_over;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lives_tracker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .start       (start),
    .miss1       (miss1),
    .miss2       (miss2),
    .lives1      (lives1),
    .lives2      (lives2),
    .ball_reset  (ball_reset),
    .play_active (play_active),
    .game_over   (game_over),
    .winner      (winner)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame tick, then one quiet cycle.
  task automatic tick_frame();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle miss pulse(s), then one quiet cycle.
  task automatic miss(input logic m1, input logic m2);
    miss1 = m1;
    miss2 = m2;
    @(negedge clk);
    miss1 = 1'b0;
    miss2 = 1'b0;
    @(negedge clk);
  endtask

  // Ball must stay held for exactly SERVE_N ticks.
  task automatic serve();
    for (int i = 0; i < SERVE_N; i++) begin
      if (i == SERVE_N - 1) begin
        check("serve_hold_ball_reset", ball_reset, 1);
        check("serve_hold_play", play_active, 0);
      end
      tick_frame();
    end
    check("serve_done_play", play_active, 1);
    check("serve_done_ball_reset", ball_reset, 0);
  endtask

  task automatic check_lives(input string tag, input logic [1:0] e1, input logic [1:0] e2);
    check({tag, "_lives1"}, lives1, e1);
    check({tag, "_lives2"}, lives2, e2);
  endtask

  initial begin
    // Reset state
    idle(2);
    check_lives("rst", 3, 3);
    check("rst_ball_reset", ball_reset, 1);
    check("rst_play", play_active, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    rst_n = 1'b1;
    idle(3);
    tick_frame();
    check("idle_play", play_active, 0);
    check("idle_ball_reset", ball_reset, 1);

    // Game 1: start, serve
    press_start();
    check("start_ball_reset", ball_reset, 1);
    check("start_play", play_active, 0);
    check_lives("start", 3, 3);
    serve();

    // miss1 held high for 5 cycles counts once
    miss1 = 1'b1;
    @(negedge clk);
    check("miss1_first_lives1", lives1, 2);
    check("miss1_to_serve", play_active, 0);
    check("miss1_ball_reset", ball_reset, 1);
    idle(4);
    miss1 = 1'b0;
    @(negedge clk);
    check_lives("miss1_held", 2, 3);
    check("miss1_held_play", play_active, 0);

    // Misses during SERVE are ignored
    miss(1'b0, 1'b1);
    miss(1'b1, 1'b1);
    check_lives("serve_miss", 2, 3);
    check("serve_miss_play", play_active, 0);
    check("serve_miss_go", game_over, 0);
    serve();

    // start during PLAY is ignored
    press_start();
    check("play_start_play", play_active, 1);
    check_lives("play_start", 2, 3);

    // Three miss2 events -> player 1 wins
    miss(1'b0, 1'b1);
    check_lives("m2a", 2, 2);
    check("m2a_play", play_active, 0);
    serve();
    miss(1'b0, 1'b1);
    check_lives("m2b", 2, 1);
    serve();
    miss(1'b0, 1'b1);
    check_lives("m2c", 2, 0);
    check("m2c_game_over", game_over, 1);
    check("m2c_winner", winner, 2'b01);
    check("m2c_ball_reset", ball_reset, 1);
    check("m2c_play", play_active, 0);

    // GAME_OVER holds through ticks, restarts on start
    for (int i = 0; i < 10; i++) tick_frame();
    check("go_hold", game_over, 1);
    check_lives("go_hold", 2, 0);
    press_start();
    check("restart_game_over", game_over, 0);
    check("restart_winner", winner, 0);
    check("restart_ball_reset", ball_reset, 1);
    check_lives("restart", 3, 3);

    // Game 2: walk to 1/1, then simultaneous miss -> draw
    serve();
    miss(1'b1, 1'b0);
    check_lives("g2a", 2, 3);
    serve();
    miss(1'b0, 1'b1);
    check_lives("g2b", 2, 2);
    serve();
    miss(1'b1, 1'b0);
    check_lives("g2c", 1, 2);
    serve();
    miss(1'b0, 1'b1);
    check_lives("g2d", 1, 1);
    serve();
    miss(1'b1, 1'b1);
    check_lives("draw", 0, 0);
    check("draw_game_over", game_over, 1);
    check("draw_winner", winner, 2'b11);

    // Game 3: reach 1/2 in PLAY, then reset mid-game
    press_start();
    check_lives("g3_start", 3, 3);
    serve();
    miss(1'b1, 1'b0);
    serve();
    miss(1'b1, 1'b0);
    serve();
    miss(1'b0, 1'b1);
    check_lives("g3_pre", 1, 2);
    serve();
    rst_n = 1'b0;
    #1;
    check_lives("midrst", 3, 3);
    check("midrst_play", play_active, 0);
    check("midrst_ball_reset", ball_reset, 1);
    check("midrst_game_over", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("postrst_play", play_active, 0);
    check("postrst_ball_reset", ball_reset, 1);

    // Game 4: player 2 wins
    press_start();
    serve();
    miss(1'b1, 1'b0);
    serve();
    miss(1'b1, 1'b0);
    serve();
    miss(1'b1, 1'b0);
    check_lives("p2win", 0, 3);
    check("p2win_game_over", game_over, 1);
    check("p2win_winner", winner, 2'b10);

    // Game-over timeout behaviour
    for (int i = 0; i < GO_N - 1; i++) tick_frame();
    check("go_before_timeout", game_over, 1);
    tick_frame();
`ifdef LIVES_AUTO_RESTART_EN
    check("autorst_game_over", game_over, 0);
    check("autorst_winner", winner, 0);
    check("autorst_ball_reset", ball_reset, 1);
    check("autorst_play", play_active, 0);
    check_lives("autorst", 3, 3);
`else
    check("no_autorst_game_over", game_over, 1);
    check("no_autorst_winner", winner, 2'b10);
    check_lives("no_autorst", 0, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
